// File: rtl/pci_arb_pkg.sv
// rtl/pci_arb_pkg.sv - shared types and helpers for the PCI bus arbiter
// Contents: arbiter state enum, per-cycle action enum, arbitration mode
// constants and the index-width helper used to size owner/rr_ptr.
package pci_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      BUSY,
      DEAD
   } arb_state_e;

   // What the grant/owner/counter registers do on the next edge.
   typedef enum logic [2:0] {
      ACT_HOLD,
      ACT_ARB,
      ACT_SAME,
      ACT_DROP,
      ACT_PARK,
      ACT_COUNT
   } arb_act_e;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   function automatic int calc_idw(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pci_arb_pick.sv
// rtl/pci_arb_pick.sv - combinational winner selection for the PCI arbiter
// Ports:
//   req    in  N    requests, active high
//   rr_ptr in  IDW  round-robin search start index
//   mode   in  1    0 = fixed priority (highest index), 1 = round-robin
//   winner out IDW  selected index (0 when valid is low)
//   valid  out 1    at least one request present
module pci_arb_pick #(
   parameter int N   = 5,
   parameter int IDW = 3
)(
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] rr_ptr,
   input  logic           mode,
   output logic [IDW-1:0] winner,
   output logic           valid
);

   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      valid  = |req;
      if (mode) begin
         // Walk offsets from farthest to nearest so the request closest to
         // rr_ptr (in ascending, wrapping order) is the last one written.
         for (int off = N - 1; off >= 0; off--) begin
            idx = int'(rr_ptr) + off;
            if (idx >= N) begin
               idx = idx - N;
            end
            if (req[idx]) begin
               winner = IDW'(idx);
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (req[i]) begin
               winner = IDW'(i);
            end
         end
      end
   end

endmodule

// File: rtl/pci_bus_arbiter.sv
// rtl/pci_bus_arbiter.sv - parametrised central PCI bus arbiter
// Optional feature macro: PCI_ARB_PARK_EN (bus parking on PARK_ID).
// Ports:
//   clk       in   1    clock, rising edge
//   rst       in   1    synchronous reset, active high
//   req_n     in   N    bus requests, active low
//   gnt_n     out  N    registered grants, active low, at most one low
//   iframe    in   1    FRAME#, active low
//   iready    in   1    IRDY#, active low
//   owner     out  IDW  index of the current grant holder
//   owner_vld out  1    some grant is asserted
//   bus_busy  out  1    registered, iframe or iready was low
module pci_bus_arbiter
   import pci_arb_pkg::*;
#(
   parameter int N_MASTERS   = 5,
   parameter int ARB_MODE    = 0,
   parameter int GNT_TIMEOUT = 16,
   parameter int PARK_ID     = 0,
   localparam int IDW        = calc_idw(N_MASTERS)
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_MASTERS-1:0] req_n,
   output logic [N_MASTERS-1:0] gnt_n,
   input  logic                 iframe,
   input  logic                 iready,
   output logic [IDW-1:0]       owner,
   output logic                 owner_vld,
   output logic                 bus_busy
);

   localparam int            CW       = calc_idw(GNT_TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(GNT_TIMEOUT - 1);

   arb_state_e           state_q, state_d;
   arb_act_e             act;
   logic [N_MASTERS-1:0] gnt_n_q, gnt_n_d;
   logic [IDW-1:0]       owner_q, owner_d;
   logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
   logic                 owner_vld_q, owner_vld_d;
   logic                 bus_busy_q, bus_busy_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   logic [N_MASTERS-1:0] req;
   logic [N_MASTERS-1:0] owner_oh;
   logic [IDW-1:0]       pick_idx;
   logic                 pick_vld;
   logic                 bus_idle;
   logic                 owner_req;
   logic                 other_req;

   assign req       = ~req_n;
   assign bus_idle  = iframe & iready;
   assign owner_oh  = N_MASTERS'(1) << owner_q;
   assign owner_req = |(req & owner_oh);
   assign other_req = |(req & ~owner_oh);

`ifdef PCI_ARB_PARK_EN
   // Parking is the only way to hold a grant while sitting in IDLE.
   logic parked;
   assign parked = (state_q == IDLE) && owner_vld_q;
`endif

   pci_arb_pick #(
      .N   (N_MASTERS),
      .IDW (IDW)
   ) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .mode   (ARB_MODE == ARB_RR),
      .winner (pick_idx),
      .valid  (pick_vld)
   );

   function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] idx);
      return (int'(idx) == N_MASTERS - 1) ? '0 : idx + 1'b1;
   endfunction

   // State register (all flops).
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_n_q     <= '1;
         owner_q     <= '0;
         owner_vld_q <= 1'b0;
         bus_busy_q  <= 1'b0;
         rr_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         gnt_n_q     <= gnt_n_d;
         owner_q     <= owner_d;
         owner_vld_q <= owner_vld_d;
         bus_busy_q  <= bus_busy_d;
         rr_ptr_q    <= rr_ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   // Next-state logic; also decides what the grant registers do.
   always_comb begin
      state_d = state_q;
      act     = ACT_HOLD;
      case (state_q)
         // DEAD is its own single cycle of no grant, but arbitrates exactly
         // like IDLE so the new owner appears on the edge that ends it.
         IDLE, DEAD: begin
`ifdef PCI_ARB_PARK_EN
            if (parked) begin
               if (!iframe) begin
                  state_d = BUSY;
                  act     = ACT_HOLD;
               end else if (other_req) begin
                  state_d = DEAD;
                  act     = ACT_DROP;
               end else if (owner_req) begin
                  state_d = GRANT;
                  act     = ACT_SAME;
               end else begin
                  act     = ACT_HOLD;
               end
            end else
`endif
            if (pick_vld && bus_idle) begin
               state_d = GRANT;
               act     = ACT_ARB;
            end else begin
               state_d = IDLE;
`ifdef PCI_ARB_PARK_EN
               act     = pick_vld ? ACT_DROP : ACT_PARK;
`else
               act     = ACT_DROP;
`endif
            end
         end
         GRANT: begin
            if (!iframe) begin
               state_d = BUSY;
               act     = ACT_HOLD;
            end else if (!owner_req || (cnt_q == CNT_LAST)) begin
               state_d = DEAD;
               act     = ACT_DROP;
            end else begin
               act     = ACT_COUNT;
            end
         end
         BUSY: begin
            if (bus_idle) begin
               if (owner_req && !other_req) begin
                  state_d = GRANT;
                  act     = ACT_SAME;
               end else begin
                  state_d = DEAD;
                  act     = ACT_DROP;
               end
            end
         end
         default: begin
            state_d = IDLE;
            act     = ACT_DROP;
         end
      endcase
   end

   // Output / datapath register inputs.
   always_comb begin
      gnt_n_d     = gnt_n_q;
      owner_d     = owner_q;
      owner_vld_d = owner_vld_q;
      rr_ptr_d    = rr_ptr_q;
      cnt_d       = cnt_q;
      bus_busy_d  = ~bus_idle;
      case (act)
         ACT_ARB: begin
            gnt_n_d     = ~(N_MASTERS'(1) << pick_idx);
            owner_d     = pick_idx;
            owner_vld_d = 1'b1;
            rr_ptr_d    = next_ptr(pick_idx);
            cnt_d       = '0;
         end
         ACT_SAME: begin
            rr_ptr_d    = next_ptr(owner_q);
            cnt_d       = '0;
         end
         ACT_DROP: begin
            gnt_n_d     = '1;
            owner_vld_d = 1'b0;
            cnt_d       = '0;
         end
         ACT_PARK: begin
            gnt_n_d     = ~(N_MASTERS'(1) << PARK_ID);
            owner_d     = IDW'(PARK_ID);
            owner_vld_d = 1'b1;
            cnt_d       = '0;
         end
         ACT_COUNT: begin
            if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   assign gnt_n     = gnt_n_q;
   assign owner     = owner_q;
   assign owner_vld = owner_vld_q;
   assign bus_busy  = bus_busy_q;

endmodule
